polar_arbiter: RTL and testbench

POLAR_ARBITER -- requirements
Module: polar_arbiter

---
 rtl/polar_arbiter.sv | 155 +++++++++++++++
 tb/tb_polar_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_arbiter.sv
// polar_arbiter: shares one pipelined polar (CORDIC) core between PORTS
// requesters. The arbiter issues at most one sample per cycle to the core, and
// an in-order tag FIFO records which port owns each sample in flight. Results
// come back in issue order and are steered to the owning port.
//
// Build option: define POLAR_ARBITER_FIXED_PRIORITY_EN to replace the
// round-robin arbiter with fixed priority, where the lowest index wins.
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. The arbiter drives s_ready[p] only in the
// same cycle it drives c_s_valid, so the two sides commit together.
module polar_arbiter #(
    parameter int WIDTH = 32,
    parameter int PORTS = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PORTS-1:0]           s_valid,
    output logic [PORTS-1:0]           s_ready,
    input  logic [PORTS*2*WIDTH-1:0]   s_data,
    output logic                       c_s_valid,
    input  logic                       c_s_ready,
    output logic [2*WIDTH-1:0]         c_s_data,
    input  logic                       c_m_valid,
    output logic                       c_m_ready,
    input  logic [2*WIDTH-1:0]         c_m_data,
    output logic [PORTS-1:0]           m_valid,
    input  logic [PORTS-1:0]           m_ready,
    output logic [2*WIDTH-1:0]         m_data,
    output logic                       err
);

    localparam int FD = DEPTH + 1;            // tag FIFO entries, one per core slot
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = (FD > 1) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);

    logic [PW-1:0] grant;
    logic          any_req;
    logic          issue;
    logic          pop;
    logic          push_ovf;
    logic          full;
    logic          empty_eff;
    logic [PW-1:0] head;

    logic [PW-1:0] tag_mem_q [FD];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

`ifdef POLAR_ARBITER_FIXED_PRIORITY_EN
    // Fixed-priority grant: the lowest requesting index wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (s_valid[k]) begin
                grant   = PW'(k);
                any_req = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] rr_q, rr_d;

    // Round-robin grant: first requester after the last accepted port.
    // Scanning from the far end lets the nearest candidate win last.
    always_comb begin
        int idx;
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = PORTS; k >= 1; k--) begin
            idx = (int'(rr_q) + k) % PORTS;
            if (s_valid[idx]) begin
                grant   = PW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // The pointer moves only on an accepted transfer, never on a stalled grant.
    always_comb begin
        rr_d = issue ? grant : rr_q;
    end

    // Round-robin pointer register; reset makes port 0 the first winner.
    always_ff @(posedge clk) begin
        if (reset) rr_q <= PW'(PORTS - 1);
        else       rr_q <= rr_d;
    end
`endif

    // A full FIFO can still accept when the head pops in the same cycle.
    // Reset gates the outputs so nothing is offered while reset is high.
    assign full      = (count_q == CW'(FD));
    assign empty_eff = reset || (count_q == '0);
    assign head      = tag_mem_q[rd_ptr_q];
    assign pop       = c_m_valid && !empty_eff && m_ready[head];
    assign issue     = !reset && any_req && c_s_ready && (!full || pop);
    assign push_ovf  = !reset && any_req && c_s_ready && full && !pop;

    // Handshake outputs: issue steering on the request side, head steering on the result side.
    always_comb begin
        s_ready = '0;
        if (issue) s_ready[grant] = 1'b1;
        c_s_valid = issue;
        c_s_data  = s_data[int'(grant)*2*WIDTH +: 2*WIDTH];
        m_valid   = '0;
        if (!empty_eff) m_valid[head] = c_m_valid;
        c_m_ready = empty_eff ? 1'b1 : m_ready[head];
        m_data    = c_m_data;
    end

    // Next-state values for the FIFO pointers, occupancy and the sticky error.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (issue) wr_ptr_d = (wr_ptr_q == AW'(FD - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = (rd_ptr_q == AW'(FD - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({issue, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = err_q || (c_m_valid && (count_q == '0)) || push_ovf;
    end

    // FIFO control and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Tag storage: only slots between the pointers are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (issue) tag_mem_q[wr_ptr_q] <= grant;
    end

    assign err = err_q;

endmodule

// File: tb/tb_polar_arbiter.sv
// Bench for polar_arbiter: a stand-in pipelined core with DEPTH+1 slots and
// full-pipeline stall, randomized port traffic, and a scoreboard that
// predicts grants, routing, data and the error flag.
module tb_polar_arbiter;

    localparam int WIDTH = 16;
    localparam int PORTS = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 2 * WIDTH;
    localparam int EW    = 2 + DW;
    localparam logic [DW-1:0] KEY = 32'hA5C3_5A3C;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [PORTS-1:0]    s_valid, s_ready, m_valid, m_ready;
    logic [PORTS*DW-1:0] s_data;
    logic                c_s_valid, c_s_ready, c_m_valid, c_m_ready, err;
    logic [DW-1:0]       c_s_data, c_m_data, m_data;

    logic [DW-1:0] sd [PORTS];
    logic          core_en;
    logic          inj_valid;

    always_comb begin
        for (int p = 0; p < PORTS; p++) s_data[p*DW +: DW] = sd[p];
    end

    polar_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .c_s_valid(c_s_valid), .c_s_ready(c_s_ready), .c_s_data(c_s_data),
        .c_m_valid(c_m_valid), .c_m_ready(c_m_ready), .c_m_data(c_m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err(err)
    );

    // ---------------- stand-in core ----------------
    logic [DEPTH:0] st_v;
    logic [DW-1:0]  st_d [DEPTH+1];
    logic           advance;
    assign advance   = !st_v[DEPTH] || c_m_ready;
    assign c_s_ready = core_en ? advance : 1'b0;
    assign c_m_valid = core_en ? st_v[DEPTH] : inj_valid;
    assign c_m_data  = st_d[DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            st_v <= '0;
        end else if (advance) begin
            st_v    <= {st_v[DEPTH-1:0], c_s_valid && c_s_ready};
            st_d[0] <= c_s_data ^ KEY;
            for (int k = 1; k <= DEPTH; k++) st_d[k] <= st_d[k-1];
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    int            acc_cyc_q[$];
    int            last_port = PORTS - 1;
    logic          err_exp = 1'b0;
    logic          lat_chk = 1'b0;
    logic [PORTS-1:0] acc_last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference grant: the spec's arbitration rule on the current request vector.
    function automatic int predict_grant(input logic [PORTS-1:0] req, input int last);
        int g;
        g = -1;
`ifdef POLAR_ARBITER_FIXED_PRIORITY_EN
        for (int p = PORTS - 1; p >= 0; p--) if (req[p]) g = p;
`else
        for (int k = PORTS; k >= 1; k--) if (req[(last + k) % PORTS]) g = (last + k) % PORTS;
`endif
        return g;
    endfunction

    // Monitor: sample away from the active edge and compare against the model.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_s_ready", 64'(s_ready), 64'(0));
            chk("rst_c_s_valid", 64'(c_s_valid), 64'(0));
            chk("rst_m_valid", 64'(m_valid), 64'(0));
            chk("rst_c_m_ready", 64'(c_m_ready), 64'(1));
            exp_q.delete();
            acc_cyc_q.delete();
            last_port = PORTS - 1;
            err_exp   = 1'b0;
            acc_last  = '0;
        end else begin
            int head, occ, g, lat;
            logic [PORTS-1:0] exp_mv, exp_sr;
            logic             pop_now, will_acc;
            logic [EW-1:0]    ent;
            chk("err", 64'(err), 64'(err_exp));
            occ     = exp_q.size();
            head    = (occ == 0) ? 0 : int'(exp_q[0][EW-1:DW]);
            exp_mv  = '0;
            if (occ != 0) exp_mv[head] = c_m_valid;
            chk("m_valid", 64'(m_valid), 64'(exp_mv));
            chk("c_m_ready", 64'(c_m_ready), (occ == 0) ? 64'(1) : 64'(m_ready[head]));
            pop_now = (occ != 0) && c_m_valid && m_ready[head];
            if (pop_now) begin
                ent = exp_q.pop_front();
                lat = cyc - acc_cyc_q.pop_front();
                chk("m_data", 64'(m_data), 64'(ent[DW-1:0]));
                if (lat_chk) chk("latency", 64'(lat), 64'(DEPTH + 1));
            end
            if (c_m_valid && occ == 0) err_exp = 1'b1;
            g        = predict_grant(s_valid, last_port);
            will_acc = (g >= 0) && c_s_ready && ((occ < DEPTH + 1) || pop_now);
            exp_sr   = '0;
            if (will_acc) exp_sr[g] = 1'b1;
            chk("s_ready", 64'(s_ready), 64'(exp_sr));
            chk("c_s_valid", 64'(c_s_valid), 64'(will_acc));
            if (will_acc) begin
                chk("c_s_data", 64'(c_s_data), 64'(sd[g]));
                exp_q.push_back({2'(g), sd[g] ^ KEY});
                acc_cyc_q.push_back(cyc);
                last_port = g;
            end
            acc_last = s_valid & s_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of traffic: ports in mask raise requests with probability pv
    // (percent); a pending request holds until accepted. m_ready bits are 1
    // with probability pr.
    task automatic gen(input int pv, input logic [PORTS-1:0] mask, input int pr);
        tick();
        for (int p = 0; p < PORTS; p++) begin
            if (!s_valid[p] || acc_last[p]) begin
                s_valid[p] = mask[p] && ($urandom_range(0, 99) < pv);
                sd[p]      = $urandom;
            end
            m_ready[p] = ($urandom_range(0, 99) < pr);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((s_valid != '0 || exp_q.size() != 0) && budget > 0) begin
            gen(0, '0, 100);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries still pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        s_valid   = '0;
        m_ready   = '1;
        core_en   = 1'b1;
        inj_valid = 1'b0;
        for (int p = 0; p < PORTS; p++) sd[p] = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Single sample from port 0: {q=0, i=1000}, exact core latency.
        lat_chk    = 1'b1;
        sd[0]      = {16'd0, 16'd1000};
        s_valid[0] = 1'b1;
        drain();

        // All ports continuously valid, all m_ready=1.
        repeat (60) gen(100, '1, 100);
        drain();
        lat_chk = 1'b0;

        // Port 2 result blocked for a while with everyone requesting.
        repeat (30) gen(100, '1, 100);
        for (int i = 0; i < 25; i++) begin
            gen(100, '1, 100);
            m_ready[2] = 1'b0;
        end
        repeat (30) gen(100, '1, 100);
        drain();

        // Random traffic with random backpressure.
        repeat (500) gen($urandom_range(20, 100), PORTS'($urandom), $urandom_range(30, 100));
        drain();

        // Only ports 1 and 3 requesting.
        repeat (40) gen(100, 4'b1010, 100);
        drain();

        // Reset in the middle of a busy stream.
        repeat (10) gen(100, '1, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (40) gen(100, '1, 100);
        drain();

        // Result injected with the core disconnected and nothing in flight.
        core_en   = 1'b0;
        repeat (2) tick();
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset   = 1'b0;
        core_en = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
